fetch_stage: RTL and testbench

//   Consumer of the hazard unit's stall outputs: owns the PC register and the IF/ID

---
 rtl/fetch_stage.sv | 53 +++++
 tb/tb_fetch_stage.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: PC register and IF/ID pipeline register with stall holds, redirect squash and debug counters
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_write,
  input  logic             IF_ID_write,
  input  logic [1:0]       s_npc,
  input  logic [31:0]      branch_target,
  input  logic [31:0]      jump_target,
  input  logic [31:0]      jr_target,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      imem_addr,
  output logic [31:0]      pc,
  output logic [31:0]      id_instr,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_pc4,
  output logic             id_valid,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  logic [31:0] pc4, target;
  logic redirect;
  always_comb begin
    pc4 = pc + 32'd4;
    target = s_npc == 2'b01 ? branch_target : s_npc == 2'b10 ? jump_target : jr_target;
    redirect = !pc_write && s_npc != 2'b00;
  end
  assign imem_addr = pc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
      id_instr <= '0;
      id_pc <= '0;
      id_pc4 <= '0;
      id_valid <= 1'b0;
      stall_cycles <= '0;
      flush_count <= '0;
    end else begin
      if (pc_write) stall_cycles <= stall_cycles + 1'b1;
      else pc <= redirect ? target : pc4;
      if (redirect) flush_count <= flush_count + 1'b1;
      if (redirect || !IF_ID_write) begin
        id_instr <= redirect ? 32'h0 : imem_rdata;
        id_valid <= !redirect;
        id_pc <= pc;
        id_pc4 <= pc4;
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed-vector self-checking bench for fetch_stage
module tb_fetch_stage;
  logic clk = 1'b0, rst, pc_write, IF_ID_write, id_valid;
  logic [1:0] s_npc;
  logic [31:0] branch_target, jump_target, jr_target, imem_rdata, imem_addr, pc, id_instr, id_pc, id_pc4;
  logic [31:0] stall_cycles, flush_count;
  int checks = 0, errors = 0;
  fetch_stage dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .IF_ID_write(IF_ID_write), .s_npc(s_npc),
    .branch_target(branch_target), .jump_target(jump_target), .jr_target(jr_target),
    .imem_rdata(imem_rdata), .imem_addr(imem_addr), .pc(pc), .id_instr(id_instr),
    .id_pc(id_pc), .id_pc4(id_pc4), .id_valid(id_valid),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction
  assign imem_rdata = word(imem_addr);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic pw, input logic iw, input logic [1:0] sel);
    pc_write = pw;
    IF_ID_write = iw;
    s_npc = sel;
  endtask
  initial begin
    rst = 1'b1;
    drive(0, 0, 2'b00);
    branch_target = 0; jump_target = 0; jr_target = 0;
    #12;
    check("rst_pc", pc, 32'h3000);
    check("rst_addr", imem_addr, 32'h3000);
    check("rst_instr", id_instr, 0);
    check("rst_valid", {31'b0, id_valid}, 0);
    check("rst_stall", stall_cycles, 0);
    check("rst_flush", flush_count, 0);
    rst = 1'b0;
    step;
    check("e1_pc", pc, 32'h3004);
    check("e1_idpc", id_pc, 32'h3000);
    check("e1_instr", id_instr, word(32'h3000));
    check("e1_valid", {31'b0, id_valid}, 1);
    check("e1_pc4", id_pc4, 32'h3004);
    step;
    check("e2_pc", pc, 32'h3008);
    check("e2_idpc", id_pc, 32'h3004);
    drive(1, 1, 2'b00);
    step;
    step;
    check("stall_pc", pc, 32'h3008);
    check("stall_idpc", id_pc, 32'h3004);
    check("stall_instr", id_instr, word(32'h3004));
    check("stall_cnt", stall_cycles, 2);
    drive(0, 0, 2'b00);
    step;
    check("resume_pc", pc, 32'h300C);
    check("resume_idpc", id_pc, 32'h3008);
    check("resume_instr", id_instr, word(32'h3008));
    drive(0, 0, 2'b01);
    branch_target = 32'h3040;
    step;
    check("br_pc", pc, 32'h3040);
    check("br_instr", id_instr, 0);
    check("br_valid", {31'b0, id_valid}, 0);
    check("br_idpc", id_pc, 32'h300C);
    check("br_idpc4", id_pc4, 32'h3010);
    check("br_flush", flush_count, 1);
    drive(0, 0, 2'b00);
    step;
    check("post_br_idpc", id_pc, 32'h3040);
    check("post_br_instr", id_instr, word(32'h3040));
    check("post_br_pc", pc, 32'h3044);
    drive(1, 1, 2'b01);
    branch_target = 32'h3080;
    step;
    check("stallbr_pc", pc, 32'h3044);
    check("stallbr_flush", flush_count, 1);
    check("stallbr_stall", stall_cycles, 3);
    check("stallbr_valid", {31'b0, id_valid}, 1);
    drive(0, 0, 2'b01);
    step;
    check("br2_pc", pc, 32'h3080);
    check("br2_flush", flush_count, 2);
    check("br2_valid", {31'b0, id_valid}, 0);
    drive(0, 1, 2'b00);
    step;
    check("ifhold_pc", pc, 32'h3084);
    check("ifhold_idpc", id_pc, 32'h3044);
    drive(0, 1, 2'b11);
    jr_target = 32'h3100;
    step;
    check("jr_pc", pc, 32'h3100);
    check("jr_idpc", id_pc, 32'h3084);
    check("jr_flush", flush_count, 3);
    drive(0, 0, 2'b10);
    jump_target = 32'h3200;
    step;
    check("j_pc", pc, 32'h3200);
    check("j_idpc", id_pc, 32'h3100);
    check("j_instr", id_instr, 0);
    check("j_flush", flush_count, 4);
    drive(0, 0, 2'b11);
    jr_target = 32'hFFFF_FFFC;
    step;
    check("top_pc", pc, 32'hFFFF_FFFC);
    drive(0, 0, 2'b00);
    step;
    check("wrap_pc", pc, 32'h0);
    check("wrap_idpc", id_pc, 32'hFFFF_FFFC);
    check("wrap_idpc4", id_pc4, 32'h0);
    check("wrap_instr", id_instr, word(32'hFFFF_FFFC));
    drive(0, 0, 2'b10);
    jump_target = 32'h3020;
    step;
    check("j2_pc", pc, 32'h3020);
    check("j2_flush", flush_count, 6);
    drive(1, 1, 2'b01);
    step;
    check("stall2_pc", pc, 32'h3020);
    check("stall2_cnt", stall_cycles, 4);
    #2;
    rst = 1'b1;
    #1;
    check("arst_pc", pc, 32'h3000);
    check("arst_valid", {31'b0, id_valid}, 0);
    check("arst_stall", stall_cycles, 0);
    check("arst_flush", flush_count, 0);
    check("arst_idpc", id_pc, 0);
    rst = 1'b0;
    drive(0, 0, 2'b00);
    step;
    check("rerun_pc", pc, 32'h3004);
    check("rerun_idpc", id_pc, 32'h3000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
